clk_div_sched: RTL and testbench

Run-time controller for the board's integer clock divider. It holds the active divide ratio and generates the divided clock with a registered output. It accepts ratio-change and stop requests over a request/acknowledge handshake and applies them only at a period boundary, so the output never shows a runt pulse. It sits between the KEY/SW front-end logic and the GPIO_0 clock output of the divider top level.

---
 rtl/clk_div_sched_if.sv | 23 ++
 rtl/clk_div_sched.sv | 147 ++++++++++++++
 tb/tb_clk_div_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_sched_if.sv
// Request/acknowledge and divided-clock signals between the front-end and clk_div_sched.
interface clk_div_sched_if #(
    parameter int unsigned W = 5
);
    logic         req;
    logic [W-1:0] n;
    logic         busy;
    logic         ack;
    logic         err;
    logic         div_clk;
    logic         tick;
    logic [W-1:0] n_cur;

    modport master (
        output req, n,
        input  busy, ack, err, div_clk, tick, n_cur
    );

    modport slave (
        input  req, n,
        output busy, ack, err, div_clk, tick, n_cur
    );
endinterface

// File: rtl/clk_div_sched.sv
// Run-time integer clock divider; ratio changes and stops take effect only at a period boundary.
module clk_div_sched #(
    parameter int unsigned W     = 5,
    parameter int unsigned MAX_N = 16,
    parameter int unsigned DEF_N = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    clk_div_sched_if.slave   ctl
);

    typedef enum logic [1:0] {START, RUN, PEND, STOP} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic [W-1:0] n_cur, n_cur_nxt;
    logic [W-1:0] n_pend, n_pend_nxt;
    logic         clk_q, clk_nxt;
    logic         tick_q, tick_nxt;
    logic         ack_q, ack_nxt;
    logic         err_q, err_nxt;
    logic         busy_q, busy_nxt;

    logic         wrap;
    logic         take;
    logic         legal;
    logic         run_wave;
    logic [W:0]   half;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= START;
            cnt    <= '0;
            n_cur  <= W'(DEF_N);
            n_pend <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            n_cur  <= n_cur_nxt;
            n_pend <= n_pend_nxt;
            clk_q  <= clk_nxt;
            tick_q <= tick_nxt;
            ack_q  <= ack_nxt;
            err_q  <= err_nxt;
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        n_cur_nxt  = n_cur;
        n_pend_nxt = n_pend;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        run_wave   = 1'b0;

        wrap  = (cnt == n_cur - W'(1));
        take  = ctl.req && ((state == RUN) || (state == STOP));
        legal = (ctl.n == '0) || ((ctl.n >= W'(2)) && (ctl.n <= W'(MAX_N)));

        case (state)
            START: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
                run_wave  = 1'b1;
            end
            RUN: begin
                run_wave = 1'b1;
                cnt_nxt  = wrap ? '0 : cnt + W'(1);
                if (take) begin
                    if (!legal) begin
                        err_nxt = 1'b1;
                    end else if (wrap) begin
                        // Accepted on the last cycle of a period: apply on this boundary, no busy phase.
                        ack_nxt = 1'b1;
                        if (ctl.n == '0) begin
                            state_nxt = STOP;
                            n_cur_nxt = '0;
                            cnt_nxt   = '0;
                            run_wave  = 1'b0;
                        end else begin
                            n_cur_nxt = ctl.n;
                        end
                    end else begin
                        n_pend_nxt = ctl.n;
                        state_nxt  = PEND;
                    end
                end
            end
            PEND: begin
                run_wave = 1'b1;
                cnt_nxt  = wrap ? '0 : cnt + W'(1);
                if (wrap) begin
                    ack_nxt = 1'b1;
                    if (n_pend == '0) begin
                        state_nxt = STOP;
                        n_cur_nxt = '0;
                        cnt_nxt   = '0;
                        run_wave  = 1'b0;
                    end else begin
                        n_cur_nxt = n_pend;
                        state_nxt = RUN;
                    end
                end
            end
            STOP: begin
                cnt_nxt = '0;
                if (take) begin
                    if (!legal) begin
                        err_nxt = 1'b1;
                    end else begin
                        ack_nxt = 1'b1;
                        if (ctl.n != '0) begin
                            state_nxt = RUN;
                            n_cur_nxt = ctl.n;
                            run_wave  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = START;
                cnt_nxt   = '0;
            end
        endcase

        // Waveform bits are derived from the next count so they register in step with it.
        half     = ({1'b0, n_cur_nxt} + 1'b1) >> 1;
        clk_nxt  = run_wave && ({1'b0, cnt_nxt} < half);
        tick_nxt = run_wave && (cnt_nxt == '0);
        busy_nxt = (state_nxt == PEND);
    end

    assign ctl.div_clk = clk_q;
    assign ctl.tick    = tick_q;
    assign ctl.ack     = ack_q;
    assign ctl.err     = err_q;
    assign ctl.busy    = busy_q;
    assign ctl.n_cur   = n_cur;

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: behavioural period/pending model plus directed literal checks.
module tb_clk_div_sched;

    localparam int W     = 5;
    localparam int MAX_N = 16;
    localparam int DEF_N = 7;

    logic clk;
    logic rst_n;

    clk_div_sched_if #(.W(W)) ctl();

    clk_div_sched #(.W(W), .MAX_N(MAX_N), .DEF_N(DEF_N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ctl     (ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Model: running/stopped flag, ratio, position within period, pending value (-1 = none).
    bit m_started;
    bit m_stopped;
    int m_n;
    int m_pos;
    int m_pend;
    bit m_ack;
    bit m_err;

    task automatic model_reset();
        m_started = 0;
        m_stopped = 0;
        m_n       = DEF_N;
        m_pos     = 0;
        m_pend    = -1;
        m_ack     = 0;
        m_err     = 0;
    endtask

    task automatic model_step(input bit r, input int v);
        if (!rst_n) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1;
            m_pos     = 0;
            m_ack     = 0;
            m_err     = 0;
        end else begin
            m_ack = 0;
            m_err = 0;
            if (r && m_pend < 0) begin
                if (v == 0 || (v >= 2 && v <= MAX_N)) m_pend = v;
                else m_err = 1;
            end
            if (m_stopped) begin
                if (m_pend >= 0) begin
                    m_ack = 1;
                    if (m_pend != 0) begin
                        m_stopped = 0;
                        m_n       = m_pend;
                        m_pos     = 0;
                    end
                    m_pend = -1;
                end
            end else if (m_pos == m_n - 1) begin
                m_pos = 0;
                if (m_pend >= 0) begin
                    m_ack = 1;
                    if (m_pend == 0) m_stopped = 1;
                    else m_n = m_pend;
                    m_pend = -1;
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic compare_outputs();
        logic [9:0] exp_v, act_v;
        bit         e_clk, e_tick, e_busy;
        int         e_ncur;
        if (!m_started) begin
            e_clk = 0; e_tick = 0; e_busy = 0; e_ncur = DEF_N;
        end else if (m_stopped) begin
            e_clk = 0; e_tick = 0; e_busy = 0; e_ncur = 0;
        end else begin
            e_clk  = (m_pos < (m_n + 1) / 2);
            e_tick = (m_pos == 0);
            e_busy = (m_pend >= 0);
            e_ncur = m_n;
        end
        exp_v = {e_clk, e_tick, m_ack, m_err, e_busy, 5'(e_ncur)};
        act_v = {ctl.div_clk, ctl.tick, ctl.ack, ctl.err, ctl.busy, ctl.n_cur};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL cycle%0d {clk,tick,ack,err,busy,n_cur}: got %b_%0d want %b_%0d",
                     cycle, act_v[9:5], act_v[4:0], exp_v[9:5], exp_v[4:0]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input int v);
        ctl.req = r;
        ctl.n   = 5'(v);
        @(posedge clk);
        model_step(r, v);
        @(negedge clk);
        cycle++;
        compare_outputs();
    endtask

    task automatic wait_tick();
        int k = 0;
        while (!ctl.tick && k < 40) begin
            cyc(0, 0);
            k++;
        end
        chk("tick_wait", int'(ctl.tick), 1);
    endtask

    initial begin
        int k, acc, ticks, hold, idle, r, v;
        rst_n   = 1'b0;
        ctl.req = 1'b0;
        ctl.n   = '0;
        model_reset();

        repeat (3) cyc(0, 0);
        chk("reset_n_cur", int'(ctl.n_cur), DEF_N);
        chk("reset_clk", int'(ctl.div_clk), 0);

        // Free run at the default ratio.
        rst_n = 1'b1;
        cyc(0, 0);
        chk("first_clk", int'(ctl.div_clk), 1);
        chk("first_tick", int'(ctl.tick), 1);
        acc = 0; ticks = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(0, 0);
            acc += int'(ctl.div_clk);
            ticks += int'(ctl.tick);
        end
        chk("n7_high_cycles", acc, 8);
        chk("n7_ticks", ticks, 2);

        // Ratio change to 4 requested at cnt = 2.
        wait_tick();
        cyc(0, 0);
        cyc(0, 0);
        cyc(1, 4);
        chk("busy_after_accept", int'(ctl.busy), 1);
        k = 0;
        while (!ctl.ack && k < 12) begin
            cyc(0, 0);
            k++;
        end
        chk("apply_latency", k, 4);
        chk("ack_with_tick", int'(ctl.tick), 1);
        chk("n_cur_4", int'(ctl.n_cur), 4);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0);
            acc += int'(ctl.div_clk);
        end
        chk("n4_high_cycles", acc, 4);

        // Illegal ratios.
        cyc(1, 1);
        chk("err_on_1", int'(ctl.err), 1);
        chk("no_ack_on_1", int'(ctl.ack), 0);
        cyc(0, 0);
        chk("err_one_cycle", int'(ctl.err), 0);
        cyc(1, 17);
        chk("err_on_17", int'(ctl.err), 1);
        cyc(0, 0);
        chk("n_cur_kept", int'(ctl.n_cur), 4);

        // Stop, then restart at 3.
        cyc(1, 0);
        k = 0;
        while (!ctl.ack && k < 10) begin
            cyc(0, 0);
            k++;
        end
        chk("stop_ack", int'(ctl.ack), 1);
        chk("stop_n_cur", int'(ctl.n_cur), 0);
        chk("stop_clk", int'(ctl.div_clk), 0);
        repeat (3) cyc(0, 0);
        cyc(1, 3);
        chk("restart_ack", int'(ctl.ack), 1);
        chk("restart_clk", int'(ctl.div_clk), 1);
        chk("restart_n_cur", int'(ctl.n_cur), 3);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0);
            acc += int'(ctl.div_clk);
        end
        chk("n3_high_cycles", acc, 4);

        // Request while busy is ignored.
        wait_tick();
        cyc(1, 5);
        chk("busy_pending_5", int'(ctl.busy), 1);
        cyc(0, 0);
        cyc(1, 9);
        acc = int'(ctl.ack);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0);
            acc += int'(ctl.ack);
        end
        chk("single_ack", acc, 1);
        chk("n_cur_5", int'(ctl.n_cur), 5);

        // Reset during a pending change to 12.
        wait_tick();
        cyc(1, 12);
        chk("busy_pending_12", int'(ctl.busy), 1);
        cyc(0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_out", int'({ctl.div_clk, ctl.tick, ctl.ack, ctl.err, ctl.busy}), 0);
        chk("async_rst_n_cur", int'(ctl.n_cur), DEF_N);
        @(negedge clk);
        cyc(0, 0);
        rst_n = 1'b1;
        acc = 0; ticks = 0;
        for (int i = 0; i < 21; i++) begin
            cyc(0, 0);
            acc += int'(ctl.ack);
            ticks += int'(ctl.tick);
        end
        chk("no_ack_after_reset", acc, 0);
        chk("ticks_after_reset", ticks, 3);
        chk("n_cur_after_reset", int'(ctl.n_cur), DEF_N);

        // Randomized requests against the model.
        for (int i = 0; i < 160; i++) begin
            idle = $urandom_range(0, 8);
            for (int j = 0; j < idle; j++) cyc(0, 0);
            r = $urandom_range(0, 9);
            if (r < 2) v = 0;
            else if (r < 3) v = 1;
            else if (r < 4) v = $urandom_range(17, 31);
            else v = $urandom_range(2, 16);
            hold = $urandom_range(1, 4);
            for (int j = 0; j < hold; j++) cyc(1, v);
        end
        repeat (20) cyc(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
